// File: rtl/pixel_writeback_packer.sv
// Pixel writeback packer: collects PIX_PER_WORD pixels from the upstream stream.
// Each full word goes out as one memory write. The final word of a frame may be
// partial, and its unfilled pixel slots are zero.
module pixel_writeback_packer #(
  parameter int W_ADDR_SIZE_BITS = 16,
  parameter int BIT_PER_PIXEL    = 8,
  parameter int PIX_PER_WORD     = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [W_ADDR_SIZE_BITS-1:0]            write_start_address,
  input  logic [24:0]                            num_pix,
  input  logic                                   pix_valid,
  input  logic [BIT_PER_PIXEL-1:0]               pix_data,
  output logic                                   pix_ready,
  input  logic                                   mem_ready,
  output logic [W_ADDR_SIZE_BITS-1:0]            address,
  output logic [PIX_PER_WORD*BIT_PER_PIXEL-1:0]  w_data,
  output logic                                   write_enable,
  output logic                                   busy,
  output logic                                   done
);

  localparam int SLOT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [SLOT_W-1:0] slot;
  logic [24:0]       remaining;
  logic              accept;
  logic              word_full;

  // Every handshake and status output is a direct decode of the current state.
  assign pix_ready    = (state == COLLECT);
  assign write_enable = (state == WRITE);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  assign accept    = pix_ready && pix_valid;
  // The word closes on its last slot, or early on the last pixel of the frame.
  assign word_full = (slot == LAST_SLOT) || (remaining == 25'd1);

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (num_pix == 25'd0) ? DONE : COLLECT;
      COLLECT: if (accept && word_full) state_next = WRITE;
      WRITE:   if (mem_ready) state_next = (remaining != 25'd0) ? COLLECT : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load the frame on start, pack accepted pixels, and advance the address on each accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      address   <= '0;
      w_data    <= '0;
      slot      <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            address   <= write_start_address;
            remaining <= num_pix;
            slot      <= '0;
            w_data    <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            w_data[slot*BIT_PER_PIXEL +: BIT_PER_PIXEL] <= pix_data;
            remaining <= remaining - 25'd1;
            slot      <= slot + 1'b1;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            slot    <= '0;
            w_data  <= '0;
            address <= address + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pixel_writeback_packer.md
PIXEL_WRITEBACK_PACKER -- requirements
Module: pixel_writeback_packer

Interface
REQ-001 Parameter W_ADDR_SIZE_BITS, default 16, SHALL set the memory word-address width.
REQ-002 Parameter BIT_PER_PIXEL, default 8, SHALL set the width of one pixel.
REQ-003 Parameter PIX_PER_WORD, default 3, SHALL set pixels packed per memory word; the word width is PIX_PER_WORD*BIT_PER_PIXEL (24).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 start  input  1  one-cycle pulse that launches a frame writeback.
REQ-007 write_start_address  input  W_ADDR_SIZE_BITS  first word address; sampled on start.
REQ-008 num_pix  input  25  total pixels in the frame; sampled on start.
REQ-009 pix_valid  input  1  upstream hysteresis stage presents a pixel.
REQ-010 pix_data  input  BIT_PER_PIXEL  final edge pixel value.
REQ-011 pix_ready  output  1  packer accepts pix_data this cycle.
REQ-012 mem_ready  input  1  memory accepts the current write this cycle.
REQ-013 address  output  W_ADDR_SIZE_BITS  word address of the current write.
REQ-014 w_data  output  24  packed write word.
REQ-015 write_enable  output  1  write request; held until accepted.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse on frame completion.

Function
REQ-018 The FSM SHALL have states IDLE, COLLECT, WRITE and DONE.
REQ-019 IDLE: on start, latch write_start_address into the address counter and num_pix into the remaining counter, then go to COLLECT; if num_pix==0, go to DONE instead.
REQ-020 The block SHALL ignore start in every state except IDLE.
REQ-021 pix_ready SHALL be 1 only in COLLECT; a pixel is accepted only when pix_valid && pix_ready.
REQ-022 The k-th accepted pixel of a word (k=0..2) SHALL be placed in w_data[8k+7:8k], so the first pixel occupies the LSBs.
REQ-023 Each accepted pixel SHALL decrement the remaining counter by 1 and increment the slot index by 1.
REQ-024 When the accepting cycle fills slot 2, or brings the remaining count to 0, the next state SHALL be WRITE.
REQ-025 In a partial final word, unfilled bytes SHALL be 0.
REQ-026 WRITE: write_enable=1, with address and w_data held stable until mem_ready is 1.
REQ-027 On a WRITE cycle with mem_ready=1: clear the slot index and w_data, and increment address by 1, wrapping modulo 2^W_ADDR_SIZE_BITS (0xFFFF -> 0x0000).
REQ-028 After an accepted write, the next state SHALL be COLLECT if remaining > 0, otherwise DONE.
REQ-029 Latency: a pixel accepted at cycle N that completes a word SHALL produce write_enable=1 at cycle N+1; with mem_ready already high, the write is accepted at N+1.
REQ-030 Throughput: a minimum of 4 cycles per 3-pixel word (3 collect + 1 write).
REQ-031 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE; busy=1 in DONE.
REQ-032 pix_valid is a don't-care outside COLLECT, and pixels are never dropped: upstream holds its pixel while pix_ready=0.
REQ-033 Exactly ceil(num_pix/3) writes SHALL be issued per frame.

Reset
REQ-034 With rst=1 at a rising edge, the next state SHALL be IDLE with address=0, w_data=0, write_enable=0, pix_ready=0, busy=0, done=0, and the slot and remaining counters at 0.
REQ-035 rst SHALL take priority over start, pix_valid and mem_ready.
REQ-036 Reset mid-frame SHALL abandon the frame with no further writes and no done pulse.

Verification
REQ-037 start, addr=0x0100, num_pix=6, pixels 11,22,33,44,55,66, mem_ready=1 -> writes (0x0100,0x332211) and (0x0101,0x665544); done pulses once; 2 writes total.
REQ-038 num_pix=4, pixels A1,B2,C3,D4 -> writes 0xC3B2A1 and then 0x0000D4 at start+1.
REQ-039 mem_ready=0 for 5 cycles during WRITE -> write_enable, address and w_data stable; pix_ready=0; the write completes on the first mem_ready=1 cycle.
REQ-040 addr=0xFFFF, num_pix=6 -> writes to 0xFFFF and then 0x0000.
REQ-041 num_pix=0 -> no write_enable; busy high for 1 cycle (DONE); done pulses one cycle after start.
REQ-042 rst asserted after 2 pixels of a 6-pixel frame -> all outputs 0 on the next cycle, no write, no done; a following start runs a fresh frame correctly.
